pht_update_ctrl: RTL and testbench
==================================

# pht_update_ctrl

Sequencing and arbitration controller for the pattern history table write port. It initialises every PHT entry to weakly-not-taken after reset or flush, and buffers branch-resolution updates from two commit ports in a small FIFO. It drains the FIFO one update per cycle into the PHT's single write port (`we_i`, `windex_i`, `taken_i`, `phr_i`). It sits between the backend commit stage and the `pht` instance inside the BPU.

## Interface

Parameters:
- `ADDR_WIDTH`, default 8: PHT index width; the table has 2^ADDR_WIDTH entries.
- `FIFO_DEPTH`, default 4: number of update buffer entries; must be a power of two and ≥2.

Ports:
- `clk` input 1: clock; single clock domain.
- `rst_n` input 1: reset, synchronous, active-low.
- `flush_i` input 1: re-initialise the table and discard pending updates.
- `upd0_valid_i` input 1: commit port 0 update request.
- `upd0_index_i` input ADDR_WIDTH: port 0 PHT index.
- `upd0_taken_i` input 1: port 0 resolved direction.
- `upd0_phr_i` input 2: port 0 counter value read at prediction time.
- `upd1_valid_i`, `upd1_index_i`, `upd1_taken_i`, `upd1_phr_i`: same as port 0, for commit port 1 (the younger port).
- `upd_ready_o` output 1: both ports may present updates this cycle.
- `busy_o` output 1: initialisation sweep in progress.
- `pht_we_o` output 1: drives PHT `we_i`.
- `pht_windex_o` output ADDR_WIDTH: drives PHT `windex_i`.
- `pht_taken_o` output 1: drives PHT `taken_i`.
- `pht_phr_o` output 2: drives PHT `phr_i`.

## Operation

- States are INIT and RUN.
- Reset (`rst_n`=0 at a clock edge) sets state=INIT, `init_cnt`=0 and the FIFO to empty (`count`=0, read and write pointers 0).
- **INIT:** one write per cycle.
  - Outputs: `pht_we_o`=1, `pht_windex_o`=`init_cnt`, `pht_phr_o`=2'b00, `pht_taken_o`=1, so the PHT writes 2'b01 (weakly not-taken).
  - `init_cnt` increments each cycle.
  - When `init_cnt`=2^ADDR_WIDTH-1 the write completes and the next state is RUN.
  - `busy_o`=1 and `upd_ready_o`=0 throughout; any `updX_valid_i` is ignored.
- **RUN:** `busy_o`=0.
  - `upd_ready_o`=1 iff free slots ≥ 2, computed from registered `count` (after the drain of the current cycle is not counted).
  - Accept: when `upd_ready_o`=1, each asserted `updX_valid_i` pushes {index, taken, phr}.
  - When both ports are valid, port 0 is enqueued first, so it is older.
  - Valid inputs while `upd_ready_o`=0 are dropped. The requester must hold its request until it sees ready.
  - Drain: when `count`≠0, `pht_we_o`=1 and `pht_windex_o`/`pht_taken_o`/`pht_phr_o` equal the FIFO head. The head pops at the clock edge.
  - When `count`=0: `pht_we_o`=0 and the other `pht_*` outputs are 0.
  - Same-cycle push and pop is allowed. Next `count` = `count` + pushes − pop; it never exceeds `FIFO_DEPTH`.
  - Pointers are log2(FIFO_DEPTH) bits and wrap modulo `FIFO_DEPTH`.
- **flush_i:** in RUN, at the clock edge: FIFO emptied, `init_cnt`=0, state=INIT.
  - The head write shown in the flush cycle is still performed; that write is harmless because INIT overwrites the whole table.
  - Updates presented in the flush cycle are discarded.
  - `flush_i` during INIT restarts the sweep at `init_cnt`=0.
- Reset has priority over flush; flush has priority over accept and drain bookkeeping.
- The controller never modifies counter values. Saturation is performed by the PHT from `phr_i` and `taken_i`.
- Updates to the same index are written in order, with no coalescing. A later update to an index carries its own stale `phr` (accepted imprecision of the predictor).

## Timing

- Reset values of outputs in the first cycle after reset:
  - `busy_o`=1, `upd_ready_o`=0, `pht_we_o`=1, `pht_windex_o`=0, `pht_phr_o`=2'b00, `pht_taken_o`=1.
  - During the reset cycle itself the state is forced, so no update is accepted.
- INIT lasts exactly 2^ADDR_WIDTH cycles after reset release. `busy_o` falls in cycle 2^ADDR_WIDTH (counting the first INIT cycle as 0).
- Update latency: an update accepted at edge N appears on the `pht_*` outputs in cycle N+1 if the FIFO was empty. Otherwise it appears after all older entries.
- Throughput: one PHT write per cycle. Sustained two-per-cycle input deasserts ready once `count` > `FIFO_DEPTH`−2.
- All outputs are combinational from registered state only, with no input-to-output paths.

## Test plan

- Reset with ADDR_WIDTH=4: indices 0..15 are written with phr=00, taken=1 in consecutive cycles; `busy_o`=0 and `upd_ready_o`=1 in cycle 16. Backdoor read of every entry = 2'b01.
- Single update in RUN, upd0 {idx 5, taken 1, phr 01}: the next cycle shows `pht_we_o`=1, `windex`=5; PHT entry 5 becomes 2'b10 one cycle later.
- Dual update, port0 idx 3 and port1 idx 7 in the same cycle: writes to 3 then 7 on consecutive cycles.
- Saturation via stimulus, phr=11 taken=1 and phr=00 taken=0: entries stay 11 and 00 respectively.
- Back-pressure with FIFO_DEPTH=4, both ports valid every cycle: ready deasserts once `count`>2. No accepted update is lost or reordered, and the write order matches the acceptance order exactly.
- Flush with 3 entries queued: the flush-cycle head write occurs, the remaining entries are never written, and the INIT sweep restarts at 0. A second flush mid-sweep restarts at 0 again.

Source files
------------

// File: rtl/pht_update_ctrl.sv
// rtl/pht_update_ctrl.sv - PHT write-port sequencer: init sweep plus buffered commit updates
// Sweeps every entry to weakly-not-taken after reset/flush, then drains a dual-push FIFO one write per cycle.
module pht_update_ctrl #(
   parameter int ADDR_WIDTH = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush_i,
   input  logic                  upd0_valid_i,
   input  logic [ADDR_WIDTH-1:0] upd0_index_i,
   input  logic                  upd0_taken_i,
   input  logic [1:0]            upd0_phr_i,
   input  logic                  upd1_valid_i,
   input  logic [ADDR_WIDTH-1:0] upd1_index_i,
   input  logic                  upd1_taken_i,
   input  logic [1:0]            upd1_phr_i,
   output logic                  upd_ready_o,
   output logic                  busy_o,
   output logic                  pht_we_o,
   output logic [ADDR_WIDTH-1:0] pht_windex_o,
   output logic                  pht_taken_o,
   output logic [1:0]            pht_phr_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = ADDR_WIDTH + 3;

   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]            state;
   logic [ADDR_WIDTH-1:0] init_cnt;
   logic [ENT_W-1:0]      fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W-1:0]      wr_ptr;
   logic [CNT_W-1:0]      count;

   logic push0;
   logic push1;
   logic pop;

   // Ready looks only at registered count so there is no input-to-output path.
   assign upd_ready_o = (state == ST_RUN) && (count <= CNT_W'(FIFO_DEPTH - 2));
   assign busy_o      = (state == ST_INIT);
   assign push0       = upd_ready_o && upd0_valid_i;
   assign push1       = upd_ready_o && upd1_valid_i;
   assign pop         = (state == ST_RUN) && (count != '0);

   always_comb begin
      pht_we_o     = 1'b0;
      pht_windex_o = '0;
      pht_taken_o  = 1'b0;
      pht_phr_o    = 2'b00;
      if (state == ST_INIT) begin
         // phr=00 with taken=1 makes the PHT store 01 (weakly not-taken).
         pht_we_o     = 1'b1;
         pht_windex_o = init_cnt;
         pht_taken_o  = 1'b1;
      end else if (count != '0) begin
         pht_we_o = 1'b1;
         {pht_windex_o, pht_taken_o, pht_phr_o} = fifo_mem[rd_ptr];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_INIT;
         init_cnt <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else if (flush_i) begin
         state    <= ST_INIT;
         init_cnt <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else if (state == ST_INIT) begin
         init_cnt <= init_cnt + 1'b1;
         if (init_cnt == {ADDR_WIDTH{1'b1}}) begin
            state <= ST_RUN;
         end
      end else begin
         wr_ptr <= wr_ptr + PTR_W'(push0) + PTR_W'(push1);
         rd_ptr <= rd_ptr + PTR_W'(pop);
         count  <= count + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
      end
   end

   // Port 0 takes the first free slot so it is the older of a same-cycle pair.
   always_ff @(posedge clk) begin
      if (rst_n && !flush_i) begin
         if (push0) begin
            fifo_mem[wr_ptr] <= {upd0_index_i, upd0_taken_i, upd0_phr_i};
         end
         if (push1) begin
            fifo_mem[wr_ptr + PTR_W'(push0)] <= {upd1_index_i, upd1_taken_i, upd1_phr_i};
         end
      end
   end

endmodule

// File: tb/tb_pht_update_ctrl.sv
// tb/tb_pht_update_ctrl.sv - directed bench for pht_update_ctrl with a 16-entry PHT model
module tb_pht_update_ctrl;

   localparam int AW = 4;
   localparam int DEPTH = 4;
   localparam int N = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_n, flush_i;
   logic          upd0_valid_i, upd0_taken_i, upd1_valid_i, upd1_taken_i;
   logic [AW-1:0] upd0_index_i, upd1_index_i;
   logic [1:0]    upd0_phr_i, upd1_phr_i;
   logic          upd_ready_o, busy_o, pht_we_o, pht_taken_o;
   logic [AW-1:0] pht_windex_o;
   logic [1:0]    pht_phr_o;

   int checks = 0;
   int errors = 0;

   logic [1:0]      pht_model [N];
   logic [AW+2:0]   write_log [$];
   logic [AW+2:0]   exp_q [$];

   pht_update_ctrl #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
      .upd0_valid_i(upd0_valid_i), .upd0_index_i(upd0_index_i),
      .upd0_taken_i(upd0_taken_i), .upd0_phr_i(upd0_phr_i),
      .upd1_valid_i(upd1_valid_i), .upd1_index_i(upd1_index_i),
      .upd1_taken_i(upd1_taken_i), .upd1_phr_i(upd1_phr_i),
      .upd_ready_o(upd_ready_o), .busy_o(busy_o), .pht_we_o(pht_we_o),
      .pht_windex_o(pht_windex_o), .pht_taken_o(pht_taken_o), .pht_phr_o(pht_phr_o)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] sat(input logic [1:0] phr, input logic taken);
      if (taken) return (phr == 2'b11) ? 2'b11 : phr + 2'b01;
      else       return (phr == 2'b00) ? 2'b00 : phr - 2'b01;
   endfunction

   // Behavioural PHT plus a log of every write made outside the init sweep.
   always @(posedge clk) begin
      if (pht_we_o) begin
         pht_model[pht_windex_o] <= sat(pht_phr_o, pht_taken_o);
         if (!busy_o) write_log.push_back({pht_windex_o, pht_taken_o, pht_phr_o});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      flush_i = 0;
      upd0_valid_i = 0; upd0_index_i = '0; upd0_taken_i = 0; upd0_phr_i = 2'b00;
      upd1_valid_i = 0; upd1_index_i = '0; upd1_taken_i = 0; upd1_phr_i = 2'b00;
   endtask

   task automatic check_sweep(input string tag);
      for (int i = 0; i < N; i++) begin
         checks++;
         if (pht_we_o !== 1'b1 || pht_windex_o !== AW'(i) || pht_taken_o !== 1'b1 ||
             pht_phr_o !== 2'b00 || busy_o !== 1'b1 || upd_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_sweep[%0d] got we=%b idx=%0d t=%b phr=%b busy=%b rdy=%b want we=1 idx=%0d t=1 phr=00 busy=1 rdy=0",
                     tag, i, pht_we_o, pht_windex_o, pht_taken_o, pht_phr_o, busy_o, upd_ready_o, i);
         end
         tick();
      end
      checks++;
      if (busy_o !== 1'b0 || upd_ready_o !== 1'b1 || pht_we_o !== 1'b0) begin
         errors++;
         $display("FAIL %s_run_entry got busy=%b rdy=%b we=%b want busy=0 rdy=1 we=0",
                  tag, busy_o, upd_ready_o, pht_we_o);
      end
      for (int i = 0; i < N; i++) begin
         checks++;
         if (pht_model[i] !== 2'b01) begin
            errors++;
            $display("FAIL %s_entry[%0d] got %b want 01", tag, i, pht_model[i]);
         end
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < N; i++) pht_model[i] = 2'b11;
      idle_inputs();
      rst_n = 0;
      upd0_valid_i = 1; upd0_index_i = 4'd9; upd0_taken_i = 1;
      tick(); tick();
      rst_n = 1;
      // Requests during INIT must be ignored; they stay asserted until the last sweep edge.
      for (int i = 0; i < N; i++) begin
         checks++;
         if (pht_we_o !== 1'b1 || pht_windex_o !== AW'(i) || busy_o !== 1'b1 || upd_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_sweep[%0d] got we=%b idx=%0d busy=%b rdy=%b want we=1 idx=%0d busy=1 rdy=0",
                     i, pht_we_o, pht_windex_o, busy_o, upd_ready_o, i);
         end
         if (i == N - 1) upd0_valid_i = 0;
         tick();
      end
      checks++;
      if (busy_o !== 1'b0 || upd_ready_o !== 1'b1 || pht_we_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_run_entry got busy=%b rdy=%b we=%b want busy=0 rdy=1 we=0",
                  busy_o, upd_ready_o, pht_we_o);
      end
      for (int i = 0; i < N; i++) begin
         checks++;
         if (pht_model[i] !== 2'b01) begin
            errors++;
            $display("FAIL reset_entry[%0d] got %b want 01", i, pht_model[i]);
         end
      end
   endtask

   task automatic test_single();
      upd0_valid_i = 1; upd0_index_i = 4'd5; upd0_taken_i = 1; upd0_phr_i = 2'b01;
      tick();
      idle_inputs();
      checks++;
      if (pht_we_o !== 1'b1 || pht_windex_o !== 4'd5 || pht_taken_o !== 1'b1 || pht_phr_o !== 2'b01) begin
         errors++;
         $display("FAIL single_write got we=%b idx=%0d t=%b phr=%b want we=1 idx=5 t=1 phr=01",
                  pht_we_o, pht_windex_o, pht_taken_o, pht_phr_o);
      end
      tick();
      checks++;
      if (pht_we_o !== 1'b0 || pht_model[5] !== 2'b10) begin
         errors++;
         $display("FAIL single_result got we=%b entry5=%b want we=0 entry5=10", pht_we_o, pht_model[5]);
      end
   endtask

   task automatic test_dual();
      upd0_valid_i = 1; upd0_index_i = 4'd3; upd0_taken_i = 0; upd0_phr_i = 2'b10;
      upd1_valid_i = 1; upd1_index_i = 4'd7; upd1_taken_i = 1; upd1_phr_i = 2'b01;
      tick();
      idle_inputs();
      checks++;
      if (pht_we_o !== 1'b1 || pht_windex_o !== 4'd3 || pht_taken_o !== 1'b0 || pht_phr_o !== 2'b10) begin
         errors++;
         $display("FAIL dual_first got we=%b idx=%0d t=%b phr=%b want we=1 idx=3 t=0 phr=10",
                  pht_we_o, pht_windex_o, pht_taken_o, pht_phr_o);
      end
      tick();
      checks++;
      if (pht_we_o !== 1'b1 || pht_windex_o !== 4'd7 || pht_taken_o !== 1'b1 || pht_phr_o !== 2'b01) begin
         errors++;
         $display("FAIL dual_second got we=%b idx=%0d t=%b phr=%b want we=1 idx=7 t=1 phr=01",
                  pht_we_o, pht_windex_o, pht_taken_o, pht_phr_o);
      end
      tick();
      checks++;
      if (pht_we_o !== 1'b0 || pht_model[3] !== 2'b01 || pht_model[7] !== 2'b10) begin
         errors++;
         $display("FAIL dual_result got we=%b e3=%b e7=%b want we=0 e3=01 e7=10",
                  pht_we_o, pht_model[3], pht_model[7]);
      end
   endtask

   task automatic test_saturation();
      upd0_valid_i = 1; upd0_index_i = 4'd9;  upd0_taken_i = 1; upd0_phr_i = 2'b11;
      upd1_valid_i = 1; upd1_index_i = 4'd10; upd1_taken_i = 0; upd1_phr_i = 2'b00;
      tick();
      idle_inputs();
      tick(); tick();
      checks++;
      if (pht_model[9] !== 2'b11 || pht_model[10] !== 2'b00) begin
         errors++;
         $display("FAIL saturation got e9=%b e10=%b want e9=11 e10=00", pht_model[9], pht_model[10]);
      end
   endtask

   task automatic set_pair(input int k);
      logic [1:0] kb;
      kb = 2'(k);
      upd0_valid_i = 1; upd0_index_i = AW'(2 * k);     upd0_taken_i = kb[0];  upd0_phr_i = kb;
      upd1_valid_i = 1; upd1_index_i = AW'(2 * k + 1); upd1_taken_i = ~kb[0]; upd1_phr_i = ~kb;
   endtask

   task automatic test_back_to_back();
      int  exp_cnt;
      int  k;
      logic exp_rdy;
      write_log.delete();
      exp_q.delete();
      exp_cnt = 0;
      k = 0;
      set_pair(k);
      for (int cyc = 0; cyc < 10; cyc++) begin
         exp_rdy = (exp_cnt <= DEPTH - 2);
         checks++;
         if (upd_ready_o !== exp_rdy) begin
            errors++;
            $display("FAIL b2b_ready[%0d] got %b want %b (count=%0d)", cyc, upd_ready_o, exp_rdy, exp_cnt);
         end
         if (exp_rdy) begin
            exp_q.push_back({upd0_index_i, upd0_taken_i, upd0_phr_i});
            exp_q.push_back({upd1_index_i, upd1_taken_i, upd1_phr_i});
         end
         exp_cnt = exp_cnt + (exp_rdy ? 2 : 0) - ((exp_cnt != 0) ? 1 : 0);
         tick();
         if (exp_rdy) begin
            k++;
            set_pair(k);
         end
      end
      idle_inputs();
      for (int i = 0; i < 8; i++) tick();
      checks++;
      if (write_log.size() != exp_q.size()) begin
         errors++;
         $display("FAIL b2b_count got %0d writes want %0d", write_log.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < write_log.size(); i++) begin
         checks++;
         if (write_log[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL b2b_order[%0d] got %h want %h", i, write_log[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_flush();
      write_log.delete();
      upd0_valid_i = 1; upd0_index_i = 4'd1; upd0_taken_i = 1; upd0_phr_i = 2'b00;
      upd1_valid_i = 1; upd1_index_i = 4'd2; upd1_taken_i = 1; upd1_phr_i = 2'b00;
      tick();
      upd0_index_i = 4'd4; upd1_index_i = 4'd6;
      tick();
      // Three entries queued (2, 4, 6); head 2 is shown during the flush cycle.
      upd0_index_i = 4'd11; upd1_index_i = 4'd12;
      flush_i = 1;
      checks++;
      if (pht_we_o !== 1'b1 || pht_windex_o !== 4'd2) begin
         errors++;
         $display("FAIL flush_head got we=%b idx=%0d want we=1 idx=2", pht_we_o, pht_windex_o);
      end
      tick();
      idle_inputs();
      for (int i = 0; i < 5; i++) tick();
      checks++;
      if (pht_windex_o !== 4'd5 || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL flush_mid got idx=%0d busy=%b want idx=5 busy=1", pht_windex_o, busy_o);
      end
      flush_i = 1;
      tick();
      flush_i = 0;
      check_sweep("flush");
      checks++;
      if (write_log.size() != 2) begin
         errors++;
         $display("FAIL flush_log_size got %0d want 2", write_log.size());
      end else begin
         checks++;
         if (write_log[0][AW+2:3] !== 4'd1 || write_log[1][AW+2:3] !== 4'd2) begin
            errors++;
            $display("FAIL flush_log got %0d,%0d want 1,2", write_log[0][AW+2:3], write_log[1][AW+2:3]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_dual();
      test_saturation();
      test_back_to_back();
      test_flush();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
